// File: rtl/vdma_vin_to_axi4s.sv
// Video input (vsync/de) to AXI4-Stream video converter with an overflow-recovering FIFO.
// Optional resolution monitor counters are built when VDMA_VIN_MONITOR_EN is defined.
module vdma_vin_to_axi4s #(
    parameter int unsigned DATA_WIDTH     = 24,
    parameter int unsigned USER_WIDTH     = 1,
    parameter int unsigned FIFO_PTR_WIDTH = 9,
    parameter int unsigned H_WIDTH        = 12,
    parameter int unsigned V_WIDTH        = 12,
    parameter bit          VSYNC_POL      = 1'b1
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  ctl_enable,
    output logic                  ctl_busy,
    input  logic                  ctl_clear_overflow,
    output logic                  ctl_overflow,
    input  logic                  vin_vsync,
    input  logic                  vin_de,
    input  logic [DATA_WIDTH-1:0] vin_data,
    output logic [USER_WIDTH-1:0] m_axi4s_tuser,
    output logic                  m_axi4s_tlast,
    output logic [DATA_WIDTH-1:0] m_axi4s_tdata,
    output logic                  m_axi4s_tvalid,
    input  logic                  m_axi4s_tready,
    output logic [H_WIDTH-1:0]    monitor_width,
    output logic [V_WIDTH-1:0]    monitor_height
);

    localparam int unsigned DEPTH  = 1 << FIFO_PTR_WIDTH;
    localparam int unsigned WORD_W = DATA_WIDTH + 2;

    typedef enum logic [1:0] {IDLE, WAIT_VSYNC, ACTIVE} state_t;

    state_t                  state_q, state_d;
    logic                    vs_q, vs_d, vs_prev_q, vs_prev_d;
    logic                    de_q, de_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    first_q, first_d;
    logic                    stg_vld_q, stg_vld_d;
    logic [DATA_WIDTH-1:0]   stg_data_q, stg_data_d;
    logic [FIFO_PTR_WIDTH:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic                    out_vld_q, out_vld_d;
    logic                    out_user_q, out_user_d;
    logic                    out_last_q, out_last_d;
    logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
    logic                    ovf_q, ovf_d;
    logic [WORD_W-1:0]       mem_q [DEPTH];

    logic                    vs_edge, fifo_empty, fifo_full, pop, push, overflow;
    logic [WORD_W-1:0]       push_word, head_word;

    always_comb begin
        vs_d      = (vin_vsync == VSYNC_POL);
        vs_prev_d = vs_q;
        de_d      = vin_de;
        data_d    = vin_data;
        vs_edge   = vs_q && !vs_prev_q;

        fifo_empty = (wr_ptr_q == rd_ptr_q);
        fifo_full  = (wr_ptr_q[FIFO_PTR_WIDTH] != rd_ptr_q[FIFO_PTR_WIDTH]) &&
                     (wr_ptr_q[FIFO_PTR_WIDTH-1:0] == rd_ptr_q[FIFO_PTR_WIDTH-1:0]);
        pop        = (!out_vld_q || m_axi4s_tready) && !fifo_empty;
        // A pop in the same cycle frees a slot, so a push on a full FIFO is then legal.
        overflow   = stg_vld_q && fifo_full && !pop;
        push       = stg_vld_q && !overflow;
        push_word  = {first_q, !de_q, stg_data_q};
        head_word  = mem_q[rd_ptr_q[FIFO_PTR_WIDTH-1:0]];

        state_d    = state_q;
        first_d    = first_q;
        stg_vld_d  = 1'b0;
        stg_data_d = stg_data_q;
        if (push) first_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (ctl_enable) state_d = WAIT_VSYNC;
            end
            WAIT_VSYNC: begin
                if (vs_edge) begin
                    state_d = ACTIVE;
                    first_d = 1'b1;
                end
            end
            ACTIVE: begin
                if (vs_edge) begin
                    if (ctl_enable) first_d = 1'b1;
                    else            state_d = IDLE;
                end
                if (de_q && !(vs_edge && !ctl_enable)) begin
                    stg_vld_d  = 1'b1;
                    stg_data_d = data_q;
                end
            end
            default: state_d = IDLE;
        endcase

        // Overflow abandons the rest of the frame and resynchronises on the next vsync.
        if (overflow) begin
            state_d   = WAIT_VSYNC;
            stg_vld_d = 1'b0;
        end

        ovf_d = ovf_q;
        if (ctl_clear_overflow) ovf_d = 1'b0;
        if (overflow)           ovf_d = 1'b1;

        wr_ptr_d = wr_ptr_q + {{FIFO_PTR_WIDTH{1'b0}}, push};
        rd_ptr_d = rd_ptr_q + {{FIFO_PTR_WIDTH{1'b0}}, pop};

        out_vld_d  = out_vld_q;
        out_user_d = out_user_q;
        out_last_d = out_last_q;
        out_data_d = out_data_q;
        if (!out_vld_q || m_axi4s_tready) begin
            out_vld_d = !fifo_empty;
            if (!fifo_empty) {out_user_d, out_last_d, out_data_d} = head_word;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q    <= IDLE;
            vs_q       <= 1'b0;
            vs_prev_q  <= 1'b0;
            de_q       <= 1'b0;
            data_q     <= '0;
            first_q    <= 1'b0;
            stg_vld_q  <= 1'b0;
            stg_data_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            out_vld_q  <= 1'b0;
            out_user_q <= 1'b0;
            out_last_q <= 1'b0;
            out_data_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            vs_q       <= vs_d;
            vs_prev_q  <= vs_prev_d;
            de_q       <= de_d;
            data_q     <= data_d;
            first_q    <= first_d;
            stg_vld_q  <= stg_vld_d;
            stg_data_q <= stg_data_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            out_vld_q  <= out_vld_d;
            out_user_q <= out_user_d;
            out_last_q <= out_last_d;
            out_data_q <= out_data_d;
            ovf_q      <= ovf_d;
        end
    end

    always_ff @(posedge aclk) begin
        if (push) mem_q[wr_ptr_q[FIFO_PTR_WIDTH-1:0]] <= push_word;
    end

    always_comb begin
        m_axi4s_tuser    = '0;
        m_axi4s_tuser[0] = out_user_q;
        m_axi4s_tlast    = out_last_q;
        m_axi4s_tdata    = out_data_q;
        m_axi4s_tvalid   = out_vld_q;
        ctl_busy         = (state_q != IDLE);
        ctl_overflow     = ovf_q;
    end

`ifdef VDMA_VIN_MONITOR_EN
    logic [H_WIDTH-1:0] pix_cnt_q, pix_cnt_d, mon_w_q, mon_w_d;
    logic [V_WIDTH-1:0] line_cnt_q, line_cnt_d, line_next, mon_h_q, mon_h_d;
    logic               de_fall;

    always_comb begin
        // A non-zero pixel count with de low marks the falling edge of de.
        de_fall    = !de_q && (pix_cnt_q != '0);
        pix_cnt_d  = pix_cnt_q;
        mon_w_d    = mon_w_q;
        mon_h_d    = mon_h_q;
        if (de_q) begin
            if (pix_cnt_q != '1) pix_cnt_d = pix_cnt_q + 1'b1;
        end else if (de_fall) begin
            mon_w_d   = pix_cnt_q;
            pix_cnt_d = '0;
        end
        line_next = line_cnt_q;
        if (de_fall && (line_cnt_q != '1)) line_next = line_cnt_q + 1'b1;
        line_cnt_d = line_next;
        if (vs_edge) begin
            line_cnt_d = '0;
            if (state_q == ACTIVE) mon_h_d = line_next;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            pix_cnt_q  <= '0;
            mon_w_q    <= '0;
            line_cnt_q <= '0;
            mon_h_q    <= '0;
        end else begin
            pix_cnt_q  <= pix_cnt_d;
            mon_w_q    <= mon_w_d;
            line_cnt_q <= line_cnt_d;
            mon_h_q    <= mon_h_d;
        end
    end

    assign monitor_width  = mon_w_q;
    assign monitor_height = mon_h_q;
`else
    assign monitor_width  = '0;
    assign monitor_height = '0;
`endif

endmodule
